// File: rtl/div_issue_ctrl.sv
// Issue/response sequencer for the 32-bit iterative divider: handles RV32M
// special cases, a one-entry DIV/REM result cache and flush/drain of runs.
module div_issue_ctrl #(
  parameter int WIDTH    = 32,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_rd,
  output logic             div_start,
  output logic             div_sign,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic             op_rem;
  logic             cache_valid;
  logic             cache_sign;
  logic [WIDTH-1:0] cache_rs1;
  logic [WIDTH-1:0] cache_rs2;
  logic [WIDTH-1:0] cache_q;
  logic [WIDTH-1:0] cache_r;

  logic             req_sign;
  logic             req_rem;
  logic             div_zero;
  logic             overflow;
  logic             cache_hit;
  logic [WIDTH-1:0] special_val;
  logic [WIDTH-1:0] hit_val;
  logic [WIDTH-1:0] done_val;

  assign req_ready = (state == IDLE);

  // Decode the incoming request: special cases take priority over the cache.
  always_comb begin
    req_sign    = ~req_op[0];
    req_rem     = req_op[1];
    div_zero    = (req_rs2 == '0);
    overflow    = req_sign && (req_rs1 == MIN) && (req_rs2 == ONES);
    cache_hit   = CACHE_EN && cache_valid && (cache_rs1 == req_rs1) &&
                  (cache_rs2 == req_rs2) && (cache_sign == req_sign);
    special_val = div_zero ? (req_rem ? req_rs1 : ONES)
                           : (req_rem ? '0 : MIN);
    hit_val     = req_rem ? cache_r : cache_q;
    done_val    = op_rem ? div_remainder : div_quotient;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_rem       <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_rd       <= '0;
      div_start    <= 1'b0;
      div_sign     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      cache_valid  <= 1'b0;
      cache_sign   <= 1'b0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_q      <= '0;
      cache_r      <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            div_dividend <= req_rs1;
            div_divisor  <= req_rs2;
            div_sign     <= req_sign;
            op_rem       <= req_rem;
            rsp_rd       <= req_rd;
            if (div_zero || overflow) begin
              rsp_data  <= special_val;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (cache_hit) begin
              rsp_data  <= hit_val;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              div_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= flush ? DRAIN : WAIT;
        end
        WAIT: begin
          // A flush that coincides with completion still discards the result.
          if (flush) begin
            state <= div_busy ? DRAIN : IDLE;
          end else if (!div_busy) begin
            rsp_data    <= done_val;
            rsp_valid   <= 1'b1;
            cache_valid <= 1'b1;
            cache_sign  <= div_sign;
            cache_rs1   <= div_dividend;
            cache_rs2   <= div_divisor;
            cache_q     <= div_quotient;
            cache_r     <= div_remainder;
            state       <= RESP;
          end
        end
        RESP: begin
          if (flush || rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        DRAIN: begin
          if (!div_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequencing front end for the iterative divider core in the EX stage of the RV32IM pipeline. It accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and holds the divider operands stable for the whole run. It applies the RV32M special cases (divide-by-zero, signed overflow) without starting the divider, and returns the 32-bit result to writeback over a second valid/ready handshake. A one-entry result cache answers a REM after a DIV on the same operands (or the reverse) in one cycle.

## Interface
- WIDTH, 32, datapath width; only 32 is supported because the divider core is fixed at 32 bits.
- CACHE_EN, 1, enables the one-entry result cache; 0 forces every non-special request through the divider.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid; equals (state==IDLE)
- req_op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; signed = ~op[0], want_rem = op[1]
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- req_rd  in  5  destination tag
- flush  in  1  kill the in-flight or pending operation
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_data  out  32  result
- rsp_rd  out  5  tag of the result
- div_start  out  1  one-cycle start pulse to the divider
- div_sign  out  1  signed operation
- div_dividend  out  32  registered dividend
- div_divisor  out  32  registered divisor
- div_quotient  in  32  divider quotient
- div_remainder  in  32  divider remainder
- div_busy  in  1  divider busy

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE, handshake fires (req_valid && !flush): capture the op, operands and rd into registers that drive div_dividend, div_divisor and div_sign. Then choose one of three paths:
  - **Special case:**
    - Divisor 0: quotient = 0xFFFFFFFF, remainder = rs1.
    - Signed, rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
    - Load the selected value into rsp_data and go to RESP.
  - **Cache hit:** requires CACHE_EN, a valid cache entry, and identical rs1, rs2 and signedness. Load the selected cached value and go to RESP.
  - **Otherwise:** go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle; go to WAIT, or to DRAIN if flush is high.
- WAIT: stay while div_busy=1. On div_busy=0, load the selected result (div_quotient or div_remainder per want_rem) into rsp_data. Write {rs1, rs2, signed, quotient, remainder} into the cache and set the cache valid. Go to RESP.
- RESP: rsp_valid=1; rsp_data and rsp_rd stay stable until rsp_ready. On rsp_ready go to IDLE.
- DRAIN: the divider cannot abort, so wait for div_busy=0, then go to IDLE. No response is issued and the cache is not written.
- The div_dividend, div_divisor and div_sign registers change only on acceptance. The divider re-reads the operand sign bits in its final cycle, so these registers must stay stable through WAIT and DRAIN.
- Flush handling by state:
  - WAIT: go to DRAIN.
  - RESP: drop the response and go to IDLE.
  - IDLE: blocks acceptance in that cycle.
  - WAIT with div_busy falling in the same cycle: flush wins; go to IDLE, no cache write.
- Cache is invalidated only by reset.

## Timing
- Reset values:
  - Outputs: rsp_valid=0, rsp_data=0, rsp_rd=0, div_start=0, div_sign=0, div_dividend=0, div_divisor=0.
  - State: IDLE, so req_ready=1.
  - Cache valid=0.
- Special case or cache hit: accept in cycle 0; rsp_valid in cycle 1.
- Divider path:
  - Accept in cycle 0; div_start in cycle 1.
  - div_busy high in cycles 2–34 (32 iterations plus the final cycle).
  - div_busy low and result captured in cycle 35; rsp_valid in cycle 36.
- WAIT never samples div_busy before cycle 2, so there is no false completion.
- Reset asserted mid-operation returns the block to IDLE immediately. The divider is reset by the same rst_n.

## Test plan
- DIV with rs1=100, rs2=7 → rsp_data=14 in cycle 36; then REM with the same operands → rsp_data=2 in cycle 1 (cache hit, no div_start).
- DIV with rs1=0xFFFFFF9C (−100), rs2=7 → 0xFFFFFFF2 (−14); REM → 0xFFFFFFFE (−2); REMU with the same operands → misses the cache and takes the divider path.
- DIVU with rs2=0 → 0xFFFFFFFF; REM with rs1=0x1234, rs2=0 → 0x1234. Both in 1 cycle, div_start never asserted.
- DIV with 0x80000000 / 0xFFFFFFFF → 0x80000000; REM on the same operands → 0. Both in 1 cycle.
- Flush in cycle 10 of a divider run → no rsp_valid and req_ready=0 until cycle 36. A following DIVU with rs1=9, rs2=2 → 4, and div_dividend stays stable throughout.
- rsp_ready held low for 5 cycles → rsp_data and rsp_rd stay stable and req_ready stays low. Asserting rst_n low during WAIT → all outputs return to their reset values.
